// File: rtl/fir_out_decim.sv
// fir_out_decim: decimate, round/saturate and buffer the FIR result stream.
// Ports: clk, rst (async, active-high); din_valid/din input samples; clr
//   clears the sticky flags; dout_valid/dout_ready/dout is the FWFT output
//   handshake; level is the FIFO occupancy; sat/overflow are sticky flags.
module fir_out_decim #(
  parameter int IN_W  = 29,
  parameter int OUT_W = 12,
  parameter int SHIFT = 11,
  parameter int DECIM = 4,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     din_valid,
  input  logic [IN_W-1:0]          din,
  input  logic                     clr,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [OUT_W-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     sat,
  output logic                     overflow
);

  localparam int PH_W = $clog2(DECIM) + 1;
  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);
  localparam logic [LW-1:0]   FULL_LV = LW'(DEPTH);

  // Rounding constant: half an output LSB, in the widened domain.
  localparam logic [IN_W:0] HALF =
    {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);

  // ---------------------------------------------------------------
  // Decimation phase
  // ---------------------------------------------------------------
  logic [PH_W-1:0] phase;
  logic            keep;

  assign keep = din_valid && (phase == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else if (din_valid) begin
      if (phase == PH_LAST) begin
        phase <= '0;
      end else begin
        phase <= phase + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------
  // Round half-up and saturate
  // ---------------------------------------------------------------
  // One extra bit so the rounding add can never wrap.
  logic [IN_W:0]      sum;
  logic [IN_W:0]      rnd;
  logic               clip;
  logic [OUT_W-1:0]   s1_nxt;

  assign sum    = {1'b0, din} + HALF;
  assign rnd    = sum >> SHIFT;
  assign clip   = |rnd[IN_W:OUT_W];
  assign s1_nxt = clip ? {OUT_W{1'b1}}
                       : rnd[OUT_W-1:0];

  // ---------------------------------------------------------------
  // Stage 1 register
  // ---------------------------------------------------------------
  logic             s1_vld;
  logic [OUT_W-1:0] s1_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_data <= '0;
    end else begin
      s1_vld <= keep;
      if (keep) begin
        s1_data <= s1_nxt;
      end
    end
  end

  // ---------------------------------------------------------------
  // FWFT FIFO
  // ---------------------------------------------------------------
  // Pointers carry a wrap bit so full and empty are distinguishable
  // and the occupancy is a plain subtraction.
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic [OUT_W-1:0]   mem [DEPTH];
  logic               full;
  logic               pop;
  logic               push;
  logic               drop;

  assign level      = wr_ptr - rd_ptr;
  assign full       = (level == FULL_LV);
  assign dout_valid = (wr_ptr != rd_ptr);
  assign pop        = dout_valid && dout_ready;

  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push = s1_vld && (!full || pop);
  assign drop = s1_vld && !push;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= s1_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
    end else if (pop) begin
      rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Head is forced to zero when empty so reset shows a clean output.
  assign dout = dout_valid ? mem[rd_ptr[AW-1:0]]
                           : '0;

  // ---------------------------------------------------------------
  // Sticky flags: a new event beats a simultaneous clear
  // ---------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat <= 1'b0;
    end else if (keep && clip) begin
      sat <= 1'b1;
    end else if (clr) begin
      sat <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr) begin
      overflow <= 1'b0;
    end
  end

endmodule
